// File: rtl/mod_exp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mod_exp_pkg                                                |
// | Description : Shared types and helpers for the modular exponentiation    |
// |               engine: FSM state encoding and the fixed-latency formula.  |
// |               Optional feature macro: MOD_EXP_EARLY_TERM_EN              |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package mod_exp_pkg;

  // Engine control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Latency from the accept cycle to the first cycle with a valid response
  // when the modulus is at least 2 and early termination is not built in:
  // one reduction phase plus one phase per exponent bit, each phase taking
  // WIDTH+1 cycles (WIDTH multiply cycles plus the hand-off cycle), plus one.
  function automatic int unsigned fixed_latency(input int unsigned width,
                                                input int unsigned exp_width);
    return (exp_width + 1) * (width + 1) + 1;
  endfunction

  // Latency for the trivial moduli 0 and 1, answered straight from IDLE
  localparam int unsigned C_SMALL_MOD_LATENCY = 1;

endpackage : mod_exp_pkg
`default_nettype wire

// File: rtl/mod_exp_engine_mod_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mod_mult                                                   |
// | Description : Bit-serial interleaved modular multiplier, MSB first.      |
// |               product = a*b mod m, requires b < m. A start pulse in      |
// |               cycle T yields done (and a valid product) in cycle T+WIDTH.|
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module mod_mult #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_m,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int c_CNT_W = $clog2(WIDTH) + 1;

  logic               r_busy;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_m;

  logic [WIDTH-1:0]   w_acc_in;
  logic               w_bit_in;
  logic [WIDTH-1:0]   w_b_in;
  logic [WIDTH-1:0]   w_m_in;
  logic [WIDTH-1:0]   w_step;

  // One interleaved step: acc' = ((2*acc mod m) + (bit ? b : 0)) mod m.
  // With acc < m and b < m both intermediate sums stay below 2m, so a
  // single conditional subtract each and WIDTH+1 bits are enough.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] acc,
                                              input logic             add,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] m);
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] sum;
    dbl = {acc, 1'b0};
    if (dbl >= {1'b0, m}) dbl = dbl - {1'b0, m};
    sum = dbl + (add ? {1'b0, b} : {(WIDTH+1){1'b0}});
    if (sum >= {1'b0, m}) sum = sum - {1'b0, m};
    return sum[WIDTH-1:0];
  endfunction

  // The start cycle already processes the MSB straight from the inputs,
  // which is what lets done land exactly WIDTH cycles after start.
  always_comb begin
    w_acc_in = i_start ? {WIDTH{1'b0}} : r_acc;
    w_bit_in = i_start ? i_a[WIDTH-1]  : r_a[WIDTH-1];
    w_b_in   = i_start ? i_b           : r_b;
    w_m_in   = i_start ? i_m           : r_m;
    w_step   = f_step(w_acc_in, w_bit_in, w_b_in, w_m_in);
  end

  // Operand capture and the bit-serial accumulate loop
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= c_CNT_W'(WIDTH - 1);
      r_acc  <= w_step;
      r_a    <= i_a << 1;
      r_b    <= i_b;
      r_m    <= i_m;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
        r_acc <= w_step;
        r_a   <= r_a << 1;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = r_acc;

endmodule : mod_mult
`default_nettype wire

// File: rtl/mod_exp_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mod_exp_engine                                             |
// | Description : base^exp mod m by right-to-left square-and-multiply using  |
// |               two bit-serial modular multipliers. Fixed latency unless   |
// |               MOD_EXP_EARLY_TERM_EN is defined, which stops as soon as   |
// |               the remaining exponent bits are all zero.                  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic [WIDTH-1:0]     base_in,
  input  logic [WIDTH-1:0]     modulus_in,
  input  logic [EXP_WIDTH-1:0] exponent_in,
  output logic                 resp_valid_out,
  input  logic                 resp_ready_in,
  output logic [WIDTH-1:0]     value_out,
  output logic                 error_out,
  output logic                 busy_out
);

  localparam int                 c_IDX_W    = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(EXP_WIDTH - 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_base;
  logic [WIDTH-1:0]     r_mod;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_r;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_start;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic [WIDTH-1:0]     r_value;
  logic                 r_error;
  logic                 r_busy;

  logic [WIDTH-1:0]     w_m0_a;
  logic [WIDTH-1:0]     w_m0_b;
  logic                 w_m0_start;
  logic                 w_m1_start;
  logic                 w_m0_done;
  logic                 w_m1_done;
  logic [WIDTH-1:0]     w_m0_p;
  logic [WIDTH-1:0]     w_m1_p;
  logic                 w_round_done;
  logic [WIDTH-1:0]     w_r_next;
  logic                 w_last_round;
  logic                 w_skip_rounds;

  // Multiplier 0 reduces the base during REDUCE and computes r*b in rounds;
  // multiplier 1 only squares b and is started in rounds only.
  always_comb begin
    w_m0_a       = (r_state == REDUCE) ? r_base : r_r;
    w_m0_b       = (r_state == REDUCE) ? WIDTH'(1) : r_b;
    w_m0_start   = r_start;
    w_m1_start   = r_start && (r_state == ROUND);
    w_round_done = w_m0_done && w_m1_done;
    w_r_next     = r_exp[r_idx] ? w_m0_p : r_r;
  end

`ifdef MOD_EXP_EARLY_TERM_EN
  logic [c_IDX_W:0]     w_idx_next;
  logic [EXP_WIDTH-1:0] w_exp_rest;

  // Stop once no set exponent bit remains above the current round
  always_comb begin
    w_idx_next    = {1'b0, r_idx} + (c_IDX_W+1)'(1);
    w_exp_rest    = r_exp >> w_idx_next;
    w_last_round  = (r_idx == c_LAST_IDX) || (w_exp_rest == '0);
    w_skip_rounds = (r_exp == '0);
  end
`else
  // Every exponent bit gets a round so timing never depends on the key
  always_comb begin
    w_last_round  = (r_idx == c_LAST_IDX);
    w_skip_rounds = 1'b0;
  end
`endif

  mod_mult #(.WIDTH(WIDTH)) u_mult_rb (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .i_start   (w_m0_start),
    .i_a       (w_m0_a),
    .i_b       (w_m0_b),
    .i_m       (r_mod),
    .o_done    (w_m0_done),
    .o_product (w_m0_p)
  );

  mod_mult #(.WIDTH(WIDTH)) u_mult_bb (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .i_start   (w_m1_start),
    .i_a       (r_b),
    .i_b       (r_b),
    .i_m       (r_mod),
    .o_done    (w_m1_done),
    .o_product (w_m1_p)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_mod        <= '0;
      r_exp        <= '0;
      r_b          <= '0;
      r_r          <= '0;
      r_idx        <= '0;
      r_start      <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_value      <= '0;
      r_error      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid_in && r_req_ready) begin
            r_base      <= base_in;
            r_mod       <= modulus_in;
            r_exp       <= exponent_in;
            r_idx       <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (modulus_in < WIDTH'(2)) begin
              // m==0 is an error, m==1 makes every residue 0
              r_state      <= DONE;
              r_value      <= '0;
              r_error      <= (modulus_in == '0);
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= REDUCE;
              r_error <= 1'b0;
              r_start <= 1'b1;
            end
          end
        end
        REDUCE: begin
          if (w_m0_done) begin
            r_b   <= w_m0_p;
            r_r   <= WIDTH'(1);
            r_idx <= '0;
            if (w_skip_rounds) begin
              r_state      <= DONE;
              r_value      <= WIDTH'(1);
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= ROUND;
              r_start <= 1'b1;
            end
          end
        end
        ROUND: begin
          if (w_round_done) begin
            // Multiply always runs; the exponent bit only selects the result
            r_r <= w_r_next;
            r_b <= w_m1_p;
            if (w_last_round) begin
              r_state      <= DONE;
              r_value      <= w_r_next;
              r_resp_valid <= 1'b1;
            end else begin
              r_idx   <= r_idx + c_IDX_W'(1);
              r_start <= 1'b1;
            end
          end
        end
        DONE: begin
          if (resp_ready_in) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_out  = r_req_ready;
  assign resp_valid_out = r_resp_valid;
  assign value_out      = r_value;
  assign error_out      = r_error;
  assign busy_out       = r_busy;

`ifndef SYNTHESIS
`ifndef MOD_EXP_EARLY_TERM_EN
  localparam int unsigned c_LATENCY = fixed_latency(WIDTH, EXP_WIDTH);
  int unsigned r_sim_cycle;

  // Cycle index since accept; every response must land at a fixed latency
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sim_cycle <= 0;
    end else begin
      case (r_state)
        IDLE:          if (req_valid_in && r_req_ready) r_sim_cycle <= 1;
        REDUCE, ROUND: r_sim_cycle <= r_sim_cycle + 1;
        DONE: begin
          if (r_sim_cycle != 0) begin
            assert ((r_sim_cycle == c_LATENCY) || (r_sim_cycle == C_SMALL_MOD_LATENCY))
              else $error("mod_exp_engine: response latency %0d off", r_sim_cycle);
          end
          r_sim_cycle <= 0;
        end
        default: r_sim_cycle <= 0;
      endcase
    end
  end
`endif
`endif

endmodule : mod_exp_engine
`default_nettype wire

// File: tb/tb_mod_exp_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mod_exp_engine                                          |
// | Description : Self-checking bench for mod_exp_engine: directed cases,    |
// |               backpressure, mid-operation reset and a random sweep       |
// |               against a plain-arithmetic modular exponentiation model.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_mod_exp_engine;
  import mod_exp_pkg::*;

  localparam int W  = 16;
  localparam int EW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          req_valid_in;
  logic          req_ready_out;
  logic [W-1:0]  base_in;
  logic [W-1:0]  modulus_in;
  logic [EW-1:0] exponent_in;
  logic          resp_valid_out;
  logic          resp_ready_in;
  logic [W-1:0]  value_out;
  logic          error_out;
  logic          busy_out;

  int            total = 0;
  int            bad   = 0;
  logic [W-1:0]  exp_val;
  logic          exp_err;
  int            exp_lat;

  mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .base_in        (base_in),
    .modulus_in     (modulus_in),
    .exponent_in    (exponent_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .value_out      (value_out),
    .error_out      (error_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #20000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Reference: square-and-multiply over 64-bit integers, latency from rules
  function automatic void model(input logic [W-1:0] b, input logic [EW-1:0] e,
                                input logic [W-1:0] m, output logic [W-1:0] v,
                                output logic err, output int lat);
    longint unsigned r;
    longint unsigned bb;
    longint unsigned mm;
    int top;
    if (m < 2) begin
      v = '0; err = (m == 0); lat = 1;
      return;
    end
    mm = 64'(m);
    r  = 1;
    bb = 64'(b) % mm;
    top = -1;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) begin
        r = (r * bb) % mm;
        top = i;
      end
      bb = (bb * bb) % mm;
    end
    v = W'(r);
    err = 1'b0;
`ifdef MOD_EXP_EARLY_TERM_EN
    lat = (top + 2) * (W + 1) + 1;
`else
    lat = int'(fixed_latency(W, EW));
`endif
  endfunction

  // Present a request and return #1 after the accepting edge
  task automatic issue(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
    int n;
    n = 0;
    model(b, e, m, exp_val, exp_err, exp_lat);
    base_in = b; exponent_in = e; modulus_in = m; req_valid_in = 1'b1;
    while (!req_ready_out && n < 2000) begin
      @(posedge clk_in); #1; n++;
    end
    if (!req_ready_out) chk("accept_timeout", 64'(req_ready_out), 64'(1));
    @(posedge clk_in); #1;
    req_valid_in = 1'b0;
    base_in = W'($urandom); exponent_in = EW'($urandom); modulus_in = W'($urandom);
  endtask

  // Wait for resp_valid_out; lat is the cycle index after the accept cycle
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid_out && lat < 5000) begin
      @(posedge clk_in); #1; lat++;
    end
  endtask

  task automatic collect(input string tag, input int hold);
    int lat;
    logic [W-1:0] v;
    wait_resp(lat);
    chk({tag, "_val"}, 64'(value_out), 64'(exp_val));
    chk({tag, "_err"}, 64'(error_out), 64'(exp_err));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    v = value_out;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_in); #1;
      chk({tag, "_hold"}, 64'({resp_valid_out, req_ready_out, busy_out, value_out}),
          64'({1'b1, 1'b0, 1'b1, v}));
    end
    resp_ready_in = 1'b1;
    @(posedge clk_in); #1;
    resp_ready_in = 1'b0;
    chk({tag, "_ack"}, 64'({resp_valid_out, req_ready_out, busy_out}), 64'(3'b010));
  endtask

  initial begin
    int lat;
    logic seen;
    logic [W-1:0] rb;
    logic [W-1:0] rm;
    logic [EW-1:0] re;
    int unsigned sel;

    rst_n_in = 1'b0; req_valid_in = 1'b0; resp_ready_in = 1'b0;
    base_in = '0; modulus_in = '0; exponent_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset", 64'({req_ready_out, resp_valid_out, busy_out, error_out, value_out}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, W'(0)}));
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // 4^13 mod 497 = 445
    issue(W'(4), EW'(13), W'(497));
    chk("busy_run", 64'({busy_out, req_ready_out}), 64'(2'b10));
    exp_val = W'(445);
`ifndef MOD_EXP_EARLY_TERM_EN
    exp_lat = 290;
`endif
    collect("t445", 0);

    issue(W'(100), EW'(3), W'(7));
    exp_val = W'(1);
    collect("t100", 1);

    issue(W'(3), EW'(0), W'(7));
    exp_val = W'(1);
`ifdef MOD_EXP_EARLY_TERM_EN
    exp_lat = 18;
`else
    exp_lat = 290;
`endif
    collect("e0", 0);

    issue(W'(5), EW'(2), W'(0));
    exp_val = '0; exp_err = 1'b1; exp_lat = 1;
    collect("m0", 2);

    issue(W'(9), EW'(4), W'(1));
    exp_val = '0; exp_err = 1'b0; exp_lat = 1;
    collect("m1", 0);

    issue(W'(0), EW'(5), W'(13));
    exp_val = '0;
    collect("b0", 0);

    // base above modulus: 1000 mod 7 = 6, 6^3 mod 7 = 6
    issue(W'(1000), EW'(3), W'(7));
    exp_val = W'(6);
    collect("bigb", 0);

    // Backpressure with a competing request held during the wait
    issue(W'(2), EW'(10), W'(1000));
    exp_val = W'(24);
    wait_resp(lat);
    chk("bp_val", 64'(value_out), 64'(exp_val));
    chk("bp_lat", 64'(lat), 64'(exp_lat));
    base_in = W'(3); exponent_in = EW'(5); modulus_in = W'(11); req_valid_in = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(posedge clk_in); #1;
      chk("bp_hold", 64'({resp_valid_out, req_ready_out, busy_out, value_out}),
          64'({1'b1, 1'b0, 1'b1, W'(24)}));
    end
    resp_ready_in = 1'b1;
    @(posedge clk_in); #1;
    resp_ready_in = 1'b0;
    chk("bp_idle", 64'({resp_valid_out, req_ready_out, busy_out}), 64'(3'b010));
    @(posedge clk_in); #1;
    req_valid_in = 1'b0;
    chk("bp_acc", 64'({req_ready_out, busy_out}), 64'(2'b01));
    model(W'(3), EW'(5), W'(11), exp_val, exp_err, exp_lat);
    exp_val = W'(1);
    collect("bp2", 0);

    // Reset 100 cycles into a running operation
    issue(W'(12345), EW'(16'hBEEF), W'(40000));
    repeat (99) @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("rst_mid", 64'({req_ready_out, resp_valid_out, busy_out, error_out, value_out}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, W'(0)}));
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    seen = 1'b0;
    repeat (400) begin
      @(posedge clk_in); #1;
      if (resp_valid_out || busy_out) seen = 1'b1;
    end
    chk("rst_quiet", 64'(seen), 64'(0));

    issue(W'(7), EW'(65535), W'(65521));
    collect("p65521", 0);

    // Random sweep
    for (int k = 0; k < 200; k++) begin
      rb = W'($urandom); re = EW'($urandom); rm = W'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) rm = W'($urandom_range(0, 3));
      if (sel == 1) re = EW'($urandom_range(0, 3));
      if (sel == 2) rb = W'($urandom_range(0, 1));
      issue(rb, re, rm);
      collect("rnd", int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mod_exp_engine
`default_nettype wire
